// File: rtl/cmd_pkg.sv
// cmd_pkg: command byte field codes, FSM states and the button-to-byte encoder
package cmd_pkg;

    localparam logic [2:0] MOT_FWD      = 3'b011;
    localparam logic [2:0] MOT_BACK     = 3'b110;
    localparam logic [2:0] MOT_HALT     = 3'b000;
    localparam logic [2:0] SRV_LEFT     = 3'b011;
    localparam logic [2:0] SRV_RIGHT    = 3'b110;
    localparam logic [2:0] SRV_STRAIGHT = 3'b101;
    localparam logic [2:0] SRV_HOLD     = 3'b000;

    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

    function automatic logic [7:0] encode(input logic fwd, input logic back, input logic left,
                                          input logic right, input logic center);
        logic [2:0] mot;
        logic [2:0] srv;
        mot = (fwd && !back) ? MOT_FWD : (back && !fwd) ? MOT_BACK : MOT_HALT;
        srv = center ? SRV_STRAIGHT : (left && !right) ? SRV_LEFT : (right && !left) ? SRV_RIGHT : SRV_HOLD;
        return {mot, srv, 2'b00};
    endfunction

endpackage

// File: rtl/cmd_encoder_btn_debounce.sv
// btn_debounce: 2-flop synchronizer followed by a stable-sample counter
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // bring the asynchronous button into the sys_clk domain
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // accept the new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            db  <= 1'b0;
        end else if (s2 == db) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt <= '0;
            db  <= s2;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cmd_encoder.sv
// cmd_encoder: debounced buttons -> command byte -> UART tx_start/tx_finish handshake
// Optional periodic resend of non-zero commands: define CMD_ENCODER_KEEPALIVE_EN.
module cmd_encoder
    import cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES   = 5_000_000,
    parameter int ACK_TIMEOUT     = 100_000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       btn_fwd,
    input  logic       btn_back,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_center,
    input  logic       tx_finish,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [7:0] cur_cmd,
    output logic       cmd_sent,
    output logic       tx_err
);

    localparam int AW = $clog2(ACK_TIMEOUT + 1);

    logic [4:0]    raw;
    logic [4:0]    db;
    logic          fin_s1;
    logic          fin_s2;
    state_t        state;
    logic          pending;
    logic [7:0]    last_sent;
    logic [AW-1:0] req_cnt;
    logic          chg;
    logic          ka_exp;
    logic          send;

    assign raw  = {btn_center, btn_right, btn_left, btn_back, btn_fwd};
    assign chg  = cur_cmd != last_sent;
    assign send = (state == IDLE) && (pending || chg || ka_exp);

    for (genvar i = 0; i < 5; i++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .sys_clk(sys_clk),
            .rst_n  (rst_n),
            .raw    (raw[i]),
            .db     (db[i])
        );
    end

`ifdef CMD_ENCODER_KEEPALIVE_EN
    localparam int KW = $clog2(REPEAT_CYCLES + 1);
    logic [KW-1:0] ka_cnt;
    assign ka_exp = (cur_cmd != 8'h00) && (ka_cnt == KW'(REPEAT_CYCLES - 1));
    // keepalive timer: restarts on each send, advances only while the command is non-zero
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) ka_cnt <= '0;
        else if (send || ka_exp) ka_cnt <= '0;
        else if (cur_cmd != 8'h00) ka_cnt <= ka_cnt + KW'(1);
    end
`else
    assign ka_exp = REPEAT_CYCLES < 0;
`endif

    // idle flag from clk_uart; resets high so the first request is not falsely acknowledged
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_s1 <= 1'b1;
            fin_s2 <= 1'b1;
        end else begin
            fin_s1 <= tx_finish;
            fin_s2 <= fin_s1;
        end
    end

    // register the encoded command for the LEDs and the sender
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) cur_cmd <= 8'h00;
        else cur_cmd <= encode(db[0], db[1], db[2], db[3], db[4]);
    end

    // send FSM: latch and request in IDLE, wait for ack in REQ, wait for idle in BUSY
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pending   <= 1'b1;
            last_sent <= 8'h00;
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
            cmd_sent  <= 1'b0;
            tx_err    <= 1'b0;
            req_cnt   <= '0;
        end else begin
            cmd_sent <= 1'b0;
            tx_err   <= 1'b0;
            pending  <= pending | chg | ka_exp;
            case (state)
                IDLE: if (send) begin
                    tx_data   <= cur_cmd;
                    last_sent <= cur_cmd;
                    pending   <= 1'b0;
                    tx_start  <= 1'b1;
                    req_cnt   <= '0;
                    state     <= REQ;
                end
                REQ: if (!fin_s2) begin
                    tx_start <= 1'b0;
                    cmd_sent <= 1'b1;
                    state    <= BUSY;
                end else if (req_cnt == AW'(ACK_TIMEOUT - 1)) begin
                    tx_start <= 1'b0;
                    tx_err   <= 1'b1;
                    pending  <= 1'b1;
                    state    <= IDLE;
                end else begin
                    req_cnt <= req_cnt + AW'(1);
                end
                BUSY: if (fin_s2) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_encoder.sv
// tb_cmd_encoder: directed scenarios plus a per-cycle behavioural model and protocol checks
module tb_cmd_encoder;

    localparam int D  = 4;
    localparam int RP = 50;
    localparam int AT = 20;

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fwd = 1'b0, back = 1'b0, left = 1'b0, right = 1'b0, center = 1'b0;
    logic       tx_finish = 1'b1;
    logic       tx_start, cmd_sent, tx_err;
    logic [7:0] tx_data, cur_cmd;

    int vectors = 0;
    int miscompares = 0;

    always #5 sys_clk = ~sys_clk;

    cmd_encoder #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(RP), .ACK_TIMEOUT(AT)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .btn_fwd   (fwd),
        .btn_back  (back),
        .btn_left  (left),
        .btn_right (right),
        .btn_center(center),
        .tx_finish (tx_finish),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .cur_cmd   (cur_cmd),
        .cmd_sent  (cmd_sent),
        .tx_err    (tx_err)
    );

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // command byte from button levels: motor*32 + servo*4, b = {center,right,left,back,fwd}
    function automatic logic [7:0] model_enc(input logic [4:0] b);
        int mot, srv;
        if (b[0] && !b[1]) mot = 3;
        else if (b[1] && !b[0]) mot = 6;
        else mot = 0;
        if (b[4]) srv = 5;
        else if (b[2] && !b[3]) srv = 3;
        else if (b[3] && !b[2]) srv = 6;
        else srv = 0;
        return 8'(mot * 32 + srv * 4);
    endfunction

    // button model: a level is accepted once it was seen D samples in a row, two cycles late
    logic [4:0] hist[$];
    logic [4:0] m_db;
    logic [7:0] exp_cur;
    logic       stable;
    always @(posedge sys_clk) begin
        if (!rst_n) begin
            hist.delete();
            for (int k = 0; k < D + 2; k++) hist.push_back(5'b0);
            m_db    = 5'b0;
            exp_cur = 8'h00;
        end else begin
            exp_cur = model_enc(m_db);
            hist.push_front({center, right, left, back, fwd});
            void'(hist.pop_back());
            for (int b = 0; b < 5; b++) begin
                stable = 1'b1;
                for (int k = 2; k < D + 2; k++) if (hist[k][b] == m_db[b]) stable = 1'b0;
                if (stable) m_db[b] = ~m_db[b];
            end
        end
    end

    // UART TX model: drops tx_finish 3 cycles after tx_start for low_len cycles
    int t = -1;
    int low_len = 10;
    bit stuck = 1'b0;
    always @(negedge sys_clk) begin
        if (!rst_n) begin
            t = -1;
            tx_finish = 1'b1;
        end else begin
            if (t < 0) begin
                if (tx_start && !stuck) t = 0;
            end else t++;
            tx_finish = !(t >= 3 && t < 3 + low_len);
            if (t >= 3 + low_len && !tx_start) t = -1;
        end
    end

    // per-cycle compare and traffic log
    logic [7:0] sent_q[$];
    int         err_cnt = 0;
    logic [7:0] prev_cur, prev_tx;
    logic       prev_start;
    int         run = 0, max_run = 0;
    always @(negedge sys_clk) begin
        if (!rst_n) begin
            prev_cur = 8'h00;
            prev_tx = 8'h00;
            prev_start = 1'b0;
            run = 0;
        end else begin
            check8("cur_cmd", cur_cmd, exp_cur);
            if (tx_start && !prev_start) check8("tx_data_latch", tx_data, prev_cur);
            else check8("tx_data_hold", tx_data, prev_tx);
            run = tx_start ? run + 1 : 0;
            if (run > max_run) max_run = run;
            if (tx_start) checki("tx_start_len_ok", int'(run <= AT), 1);
            checki("pulse_exclusive", int'(cmd_sent & tx_err), 0);
            if (cmd_sent) sent_q.push_back(tx_data);
            if (tx_err) err_cnt++;
            prev_cur = cur_cmd;
            prev_tx = tx_data;
            prev_start = tx_start;
        end
    end

    function automatic logic [7:0] qget(input int i);
        return (i >= 0 && i < sent_q.size()) ? sent_q[i] : 8'hxx;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic wait_for(input string name, input int lim, input bit on_start);
        int n = 0;
        while (!(on_start ? tx_start : cmd_sent) && n < lim) begin
            @(negedge sys_clk);
            n++;
        end
        vectors++;
        if (n >= lim) begin
            miscompares++;
            $display("FAIL %s: no event after %0d cycles, required within %0d", name, n, lim);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick(3);
        check8("rst_tx_data", tx_data, 8'h00);
        check8("rst_cur_cmd", cur_cmd, 8'h00);
        checki("rst_tx_start", int'(tx_start), 0);
        checki("rst_cmd_sent", int'(cmd_sent), 0);
        checki("rst_tx_err", int'(tx_err), 0);
        rst_n = 1'b1;
        tick(40);
        checki("s1_count", sent_q.size(), 1);
        check8("s1_byte", qget(0), 8'h00);
        checki("s1_err", err_cnt, 0);

        sent_q.delete();
        fwd = 1'b1;
        left = 1'b1;
`ifdef CMD_ENCODER_KEEPALIVE_EN
        tick(140);
        checki("s2_repeats", int'(sent_q.size() >= 2), 1);
        check8("s2_second", qget(1), 8'h6C);
`else
        tick(40);
        checki("s2_count", sent_q.size(), 1);
`endif
        check8("s2_cur", cur_cmd, 8'h6C);
        check8("s2_first", qget(0), 8'h6C);
        fwd = 1'b0;
        left = 1'b0;
        tick(40);
        check8("s2_release", qget(sent_q.size() - 1), 8'h00);

        sent_q.delete();
        left = 1'b1;
        right = 1'b1;
        center = 1'b1;
        tick(40);
        check8("s3_cur", cur_cmd, 8'h14);
        center = 1'b0;
        tick(40);
        checki("s3_count", sent_q.size(), 2);
        check8("s3_first", qget(0), 8'h14);
        check8("s3_second", qget(1), 8'h00);
        left = 1'b0;
        right = 1'b0;
        tick(20);

        sent_q.delete();
        repeat (4) begin
            back = 1'b1;
            tick(2);
            back = 1'b0;
            tick(2);
        end
        tick(20);
        checki("s4_bounce_count", sent_q.size(), 0);
        check8("s4_bounce_cur", cur_cmd, 8'h00);
        back = 1'b1;
        tick(10);
        back = 1'b0;
        tick(50);
        checki("s4_count", sent_q.size(), 2);
        check8("s4_first", qget(0), 8'hC0);
        check8("s4_second", qget(1), 8'h00);

        sent_q.delete();
        err_cnt = 0;
        max_run = 0;
        stuck = 1'b1;
        fwd = 1'b1;
        tick(60);
        check8("s5_cur", cur_cmd, 8'h60);
        check8("s5_tx_data", tx_data, 8'h60);
        checki("s5_max_run", max_run, AT);
        checki("s5_err_ge2", int'(err_cnt >= 2), 1);
        checki("s5_nosend", sent_q.size(), 0);
        stuck = 1'b0;
        wait_for("s5_retry_send", 60, 1'b0);
        tick(2);
        check8("s5_retry_byte", qget(0), 8'h60);
        fwd = 1'b0;
        tick(60);
        check8("s5_release", qget(sent_q.size() - 1), 8'h00);

        sent_q.delete();
        low_len = 40;
        fwd = 1'b1;
        wait_for("s6_first", 40, 1'b0);
        fwd = 1'b0;
        back = 1'b1;
        tick(12);
        back = 1'b0;
        tick(12);
        check8("s6_cur", cur_cmd, 8'h00);
        check8("s6_tx_data_busy", tx_data, 8'h60);
        checki("s6_no_start_busy", int'(tx_start), 0);
        tick(1);
        wait_for("s6_second", 80, 1'b0);
        tick(60);
        checki("s6_count", sent_q.size(), 2);
        check8("s6_first_byte", qget(0), 8'h60);
        check8("s6_second_byte", qget(1), 8'h00);
        low_len = 10;

        sent_q.delete();
        fwd = 1'b1;
        wait_for("s7_start", 40, 1'b1);
        tick(1);
        #2 rst_n = 1'b0;
        #1;
        checki("s7_rst_tx_start", int'(tx_start), 0);
        check8("s7_rst_tx_data", tx_data, 8'h00);
        check8("s7_rst_cur_cmd", cur_cmd, 8'h00);
        checki("s7_rst_cmd_sent", int'(cmd_sent), 0);
        checki("s7_rst_tx_err", int'(tx_err), 0);
        fwd = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(40);
        checki("s7_count", sent_q.size(), 1);
        check8("s7_halt", qget(0), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
